// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle expiry pulse and optional auto-reload.
// state | meaning
// IDLE  | stopped, counter holds, enb ignored
// RUN   | counting down on enabled cycles, cnt_out >= 1
module countdown_timer #(
  parameter int WIDTH       = 5,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt_q, cnt_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             done_q, done_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      reload_reg <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt_q      <= cnt_next;
      reload_reg <= reload_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt_q;
    reload_next = reload_reg;
    done_next   = 1'b0;
    if (load) begin
      cnt_next    = cnt_in;
      reload_next = cnt_in;
      state_next  = (cnt_in != '0) ? RUN : IDLE;
    end else if (state == RUN && enb) begin
      if (cnt_q > ONE) begin
        cnt_next = cnt_q - ONE;
      end else if (cnt_q == ONE) begin
        // Expiry edge: a zero count is never decremented, so underflow cannot occur.
        done_next = 1'b1;
        if (AUTO_RELOAD) begin
          cnt_next = reload_reg;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = (state == RUN);
  assign done    = done_q;

endmodule
